// File: rtl/noc_output_arbiter_pkg.sv
// noc_output_arbiter_pkg
// Shared constants and types for the wormhole output arbiter.
//   PORTS_CNT     : number of input ports competing for one output
//   LOG_PORTS_CNT : width of a port index
//   FLIT_SIZE     : flit width in bits; the two MSBs carry the flit type
//   FLIT_TYPE_HI / FLIT_TYPE_LO : type-field bit offsets counted from the flit MSB
package noc_output_arbiter_pkg;

    localparam int PORTS_CNT     = 5;
    localparam int LOG_PORTS_CNT = 3;
    localparam int FLIT_SIZE     = 34;

    // Type field sits in the two MSBs: flit[FLIT_SIZE-1-FLIT_TYPE_HI -: 2]
    localparam int FLIT_TYPE_HI  = 0;
    localparam int FLIT_TYPE_LO  = 1;
    localparam int FLIT_TYPE_W   = 2;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // True for flit types that may open a new packet (head or single)
    function automatic logic opens_packet(input flit_type_e t);
        logic r;
        case (t)
            FLIT_HEAD, FLIT_SINGLE: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/noc_output_arbiter_rr_pick.sv
// noc_output_arbiter_rr_pick
// Combinational round-robin picker: scans req_i starting at start_i and
// wrapping modulo N, returning the first requester.
//   req_i    : request vector
//   start_i  : index with the highest priority this cycle
//   onehot_o : one-hot winner (all zero when nobody requests)
//   idx_o    : binary winner index (zero when nobody requests)
//   any_o    : at least one request present
module noc_output_arbiter_rr_pick #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] start_i,
    output logic [N-1:0] onehot_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    // Rotating priority scan; first hit from start_i wins
    always_comb begin : pick_scan
        int         pos;
        logic [W-1:0] pos_idx;
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        pos      = 0;
        pos_idx  = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end else begin
                pos = pos;
            end
            pos_idx = W'(pos);
            if (!any_o && req_i[pos_idx]) begin
                any_o             = 1'b1;
                onehot_o[pos_idx] = 1'b1;
                idx_o             = pos_idx;
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter
// Wormhole arbiter for one router output port. Packets from PORTS inputs are
// served round-robin; once a head flit wins, the output stays locked to that
// input until its tail flit passes. Flits leave through a registered
// valid/ready stage.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   req        : per-input "flit routed to this output" flags
//   flits_in   : input i flit at [i*FLIT_SIZE +: FLIT_SIZE]
//   grant      : one-hot, combinational; input flit consumed this cycle
//   out_valid  : out_flit holds a valid flit
//   out_flit   : registered output flit
//   out_ready  : downstream accepts out_flit this cycle
//   owner      : current lock owner (meaningful while locked=1)
//   locked     : output is mid-packet
//   proto_err  : sticky; set when the owner sends a head/single mid-packet
//   pkt_cnt    : wrapping count of forwarded packet ends (tail or single)
module noc_output_arbiter
    import noc_output_arbiter_pkg::*;
#(
    parameter int PORTS     = PORTS_CNT,
    parameter int FLIT_SIZE = noc_output_arbiter_pkg::FLIT_SIZE,
    parameter int LOG_PORTS = LOG_PORTS_CNT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PORTS-1:0]           req,
    input  logic [PORTS*FLIT_SIZE-1:0] flits_in,
    output logic [PORTS-1:0]           grant,
    output logic                       out_valid,
    output logic [FLIT_SIZE-1:0]       out_flit,
    input  logic                       out_ready,
    output logic [LOG_PORTS-1:0]       owner,
    output logic                       locked,
    output logic                       proto_err,
    output logic [15:0]                pkt_cnt
);

    arb_state_e           state_q, state_d;
    logic [LOG_PORTS-1:0] rr_ptr_q, rr_ptr_d;
    logic [LOG_PORTS-1:0] owner_q, owner_d;
    logic                 out_valid_q, out_valid_d;
    logic [FLIT_SIZE-1:0] out_flit_q, out_flit_d;
    logic                 proto_err_q, proto_err_d;
    logic [15:0]          pkt_cnt_q, pkt_cnt_d;

    logic [FLIT_SIZE-1:0] flit_arr_s [PORTS];
    logic [PORTS-1:0]     eligible_s;
    logic [PORTS-1:0]     pick_onehot_s;
    logic [LOG_PORTS-1:0] pick_idx_s;
    logic                 pick_any_s;
    logic                 can_load_s;
    logic [PORTS-1:0]     grant_s;

    function automatic logic [LOG_PORTS-1:0] next_port(input logic [LOG_PORTS-1:0] idx);
        logic [LOG_PORTS-1:0] r;
        if (idx == LOG_PORTS'(PORTS - 1)) begin
            r = '0;
        end else begin
            r = idx + LOG_PORTS'(1);
        end
        return r;
    endfunction

    function automatic flit_type_e type_of(input logic [FLIT_SIZE-1:0] f);
        return flit_type_e'(f[FLIT_SIZE-1 -: FLIT_TYPE_W]);
    endfunction

    // Unpack the flat flit bus; only head/single flits may compete in IDLE
    for (genvar i = 0; i < PORTS; i++) begin : g_unpack
        assign flit_arr_s[i] = flits_in[i*FLIT_SIZE +: FLIT_SIZE];
        assign eligible_s[i] = req[i] & opens_packet(type_of(flit_arr_s[i]));
    end

    noc_output_arbiter_rr_pick #(
        .N (PORTS),
        .W (LOG_PORTS)
    ) u_rr_pick (
        .req_i    (eligible_s),
        .start_i  (rr_ptr_q),
        .onehot_o (pick_onehot_s),
        .idx_o    (pick_idx_s),
        .any_o    (pick_any_s)
    );

    assign can_load_s = !out_valid_q || out_ready;

    // Next-state logic: arbitration, lock tracking, output stage and counters
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        proto_err_d = proto_err_q;
        pkt_cnt_d   = pkt_cnt_q;
        grant_s     = '0;
        // Without a new grant the stage drains on out_ready and otherwise holds
        out_valid_d = out_valid_q && !out_ready;
        out_flit_d  = out_flit_q;
        case (state_q)
            ST_IDLE: begin
                if (can_load_s && pick_any_s) begin
                    grant_s     = pick_onehot_s;
                    out_valid_d = 1'b1;
                    out_flit_d  = flit_arr_s[pick_idx_s];
                    if (type_of(flit_arr_s[pick_idx_s]) == FLIT_SINGLE) begin
                        rr_ptr_d  = next_port(pick_idx_s);
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = pick_idx_s;
                    end
                end else begin
                    grant_s = '0;
                end
            end
            ST_LOCKED: begin
                if (can_load_s && req[owner_q]) begin
                    grant_s[owner_q] = 1'b1;
                    out_valid_d      = 1'b1;
                    out_flit_d       = flit_arr_s[owner_q];
                    case (type_of(flit_arr_s[owner_q]))
                        FLIT_TAIL: begin
                            state_d   = ST_IDLE;
                            rr_ptr_d  = next_port(owner_q);
                            pkt_cnt_d = pkt_cnt_q + 16'd1;
                        end
                        FLIT_HEAD, FLIT_SINGLE: begin
                            // A packet opener inside a packet is demoted to body
                            out_flit_d  = {FLIT_BODY, flit_arr_s[owner_q][FLIT_SIZE-3:0]};
                            proto_err_d = 1'b1;
                        end
                        default: begin
                            out_flit_d = flit_arr_s[owner_q];
                        end
                    endcase
                end else begin
                    grant_s = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            proto_err_q <= 1'b0;
            pkt_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            proto_err_q <= proto_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // Grant is combinational, so it is forced low while reset is held
    assign grant     = grant_s & {PORTS{rst_n}};
    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign owner     = owner_q;
    assign locked    = (state_q == ST_LOCKED);
    assign proto_err = proto_err_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter
// Directed stimulus with a packet-level reference model of the arbiter and a
// per-cycle compare process, plus hand-computed literal expectations.
module tb_noc_output_arbiter;
    import noc_output_arbiter_pkg::*;

    localparam int P  = 5;
    localparam int FS = 34;
    localparam int LP = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [P-1:0]    req = '0;
    logic [P*FS-1:0] flits_in = '0;
    logic            out_ready = 1'b1;
    logic [P-1:0]    grant;
    logic            out_valid;
    logic [FS-1:0]   out_flit;
    logic [LP-1:0]   owner;
    logic            locked;
    logic            proto_err;
    logic [15:0]     pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit done = 1'b0;

    // Reference model state
    bit            m_locked;
    int            m_owner;
    int            m_rr;
    bit            m_valid;
    logic [FS-1:0] m_flit;
    bit            m_perr;
    logic [15:0]   m_cnt;

    noc_output_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .flits_in  (flits_in),
        .grant     (grant),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_ready (out_ready),
        .owner     (owner),
        .locked    (locked),
        .proto_err (proto_err),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [FS-1:0] port_flit(input int i);
        return flits_in[i*FS +: FS];
    endfunction

    function automatic logic [1:0] port_type(input int i);
        logic [FS-1:0] f;
        f = port_flit(i);
        return f[FS-1 -: 2];
    endfunction

    // Which input the rules say is consumed now (-1: none)
    function automatic int model_grant();
        logic [1:0] t;
        int i;
        if (!rst_n) return -1;
        if (m_valid && !out_ready) return -1;
        if (m_locked) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < P; k++) begin
            i = (m_rr + k) % P;
            t = port_type(i);
            if (req[i] && (t == 2'b01 || t == 2'b11)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0; m_owner = 0; m_rr = 0; m_valid = 1'b0;
        m_flit = '0; m_perr = 1'b0; m_cnt = 16'd0;
    endtask

    task automatic model_step();
        int g;
        logic [1:0] t;
        g = model_grant();
        if (g < 0) begin
            if (out_ready) m_valid = 1'b0;
        end else begin
            t = port_type(g);
            m_valid = 1'b1;
            m_flit  = port_flit(g);
            if (!m_locked) begin
                if (t == 2'b11) begin
                    m_rr  = (g + 1) % P;
                    m_cnt = m_cnt + 16'd1;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end
            end else if (t == 2'b10) begin
                m_locked = 1'b0;
                m_rr     = (m_owner + 1) % P;
                m_cnt    = m_cnt + 16'd1;
            end else if (t != 2'b00) begin
                m_flit[FS-1 -: 2] = 2'b00;
                m_perr = 1'b1;
            end
        end
    endtask

    // Model advances on each edge, or resets asynchronously
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare process: every falling edge, away from the active edge
    initial begin
        int g;
        logic [P-1:0] eg;
        forever begin
            @(negedge clk);
            if (!done) begin
                g  = model_grant();
                eg = (g < 0) ? '0 : (P'(1) << g);
                chk("grant", 64'(grant), 64'(eg));
                chk("out_valid", 64'(out_valid), 64'(m_valid));
                chk("out_flit", 64'(out_flit), 64'(m_flit));
                chk("locked", 64'(locked), 64'(m_locked));
                if (m_locked) chk("owner", 64'(owner), 64'(m_owner));
                chk("proto_err", 64'(proto_err), 64'(m_perr));
                chk("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setp(input int i, input bit on, input logic [1:0] t, input logic [31:0] pl);
        req[i] = on;
        flits_in[i*FS +: FS] = {t, pl};
    endtask

    task automatic clear_all();
        req = '0;
    endtask

    // Assert reset mid-cycle and check outputs drop without a clock edge
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_flit", 64'(out_flit), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        clear_all();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held: a request must not be granted
        step(); step();
        setp(0, 1'b1, 2'b11, 32'h0000_0011);
        #1;
        chk("grant_in_reset", 64'(grant), 64'd0);
        chk("pkt_cnt_in_reset", 64'(pkt_cnt), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("first_grant", 64'(grant), 64'h01);
        step();
        chk("first_valid", 64'(out_valid), 64'd1);
        chk("first_cnt", 64'(pkt_cnt), 64'd1);
        chk("first_flit", 64'(out_flit), {30'd0, 2'b11, 32'h0000_0011});
        // rr_ptr now 1: with 0 and 1 both offering singles, 1 wins
        setp(1, 1'b1, 2'b11, 32'h0000_0021);
        #1;
        chk("rr_after_single", 64'(grant), 64'h02);
        step();
        clear_all();
        mid_reset();

        // Two heads, pointer 0: input 0 holds the output until its tail
        setp(0, 1'b1, 2'b01, 32'hA0);
        setp(3, 1'b1, 2'b01, 32'hB0);
        #1;
        chk("head_winner", 64'(grant), 64'h01);
        step();
        chk("locked_after_head", 64'(locked), 64'd1);
        chk("owner_after_head", 64'(owner), 64'd0);
        setp(0, 1'b1, 2'b00, 32'hA1); step();
        setp(0, 1'b1, 2'b00, 32'hA2); step();
        setp(0, 1'b1, 2'b10, 32'hA3); step();
        chk("unlocked_after_tail", 64'(locked), 64'd0);
        setp(0, 1'b0, 2'b00, 32'h0);
        #1;
        chk("second_head", 64'(grant), 64'h08);
        step();
        chk("owner_second", 64'(owner), 64'd3);
        setp(3, 1'b1, 2'b10, 32'hB1); step();
        setp(3, 1'b0, 2'b00, 32'h0);

        // Body flit in IDLE stalls without raising an error
        setp(1, 1'b1, 2'b00, 32'hDEAD);
        #1;
        chk("idle_body_stall", 64'(grant), 64'd0);
        step(); step();
        chk("idle_body_no_err", 64'(proto_err), 64'd0);
        setp(1, 1'b0, 2'b00, 32'h0);

        // Backpressure holds the output flit; release grants the same cycle
        setp(1, 1'b1, 2'b01, 32'hC0);
        step();
        out_ready = 1'b0;
        setp(1, 1'b1, 2'b00, 32'hC1);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_grant", 64'(grant), 64'd0);
            chk("bp_flit", 64'(out_flit), {30'd0, 2'b01, 32'hC0});
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_grant", 64'(grant), 64'h02);
        step();
        chk("bp_next_flit", 64'(out_flit), {30'd0, 2'b00, 32'hC1});
        setp(1, 1'b1, 2'b10, 32'hC2); step();
        setp(1, 1'b0, 2'b00, 32'h0);
        step();
        mid_reset();

        // All inputs stream singles: strict rotation from pointer 0
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < P; i++) setp(i, 1'b1, 2'b11, 32'(k * 16 + i));
            #1;
            chk("rotation", 64'(grant), 64'(P'(1) << (k % P)));
            step();
        end
        clear_all();
        chk("ten_packets", 64'(pkt_cnt), 64'd10);

        // Owner 2 repeats a head mid-packet: forwarded as body, sticky error
        setp(2, 1'b1, 2'b01, 32'hD0); step();
        setp(2, 1'b1, 2'b01, 32'hD1); step();
        chk("perr_set", 64'(proto_err), 64'd1);
        chk("perr_locked", 64'(locked), 64'd1);
        chk("perr_demoted", 64'(out_flit), {30'd0, 2'b00, 32'hD1});
        setp(2, 1'b1, 2'b00, 32'hD2); step();
        setp(2, 1'b1, 2'b10, 32'hD3); step();
        setp(2, 1'b0, 2'b00, 32'h0);
        chk("perr_sticky", 64'(proto_err), 64'd1);

        // Counter wrap at 0xFFFF
        setp(4, 1'b1, 2'b01, 32'hE0); step();
        #1;
        force dut.pkt_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        #1;
        release dut.pkt_cnt_q;
        setp(4, 1'b1, 2'b10, 32'hE1);
        step();
        setp(4, 1'b0, 2'b00, 32'h0);
        chk("cnt_wrap", 64'(pkt_cnt), 64'd0);
        step(); step();

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
